wb_ram_responder: RTL and testbench
===================================

# wb_ram_responder

Wishbone-style pipelined responder that terminates the CPU memory path: it accepts single-beat word-addressed requests with per-byte lane selects from `cpu_mem_controller` and answers each with one ack pulse after a fixed latency. It holds a byte-lane-writable word memory and returns full 32-bit words on reads. The initiator does its own byte/halfword lane extraction and sign extension. One request is outstanding at a time, and backpressure is signalled through `o_wb_stall`.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth = 2^ADDR_WIDTH words.
- `LATENCY`, default 1: cycles from request acceptance to ack; legal range 1..16.
- `i_clk`  in  1  sole clock; all logic on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `i_wb_stb`  in  1  request strobe, qualified by `!o_wb_stall`.
- `i_wb_we`  in  1  1 = write, 0 = read.
- `i_wb_addr`  in  32  word address; only bits `[ADDR_WIDTH-1:0]` are used.
- `i_wb_sel`  in  4  byte-lane enables; bit k covers data bits `[8k+7:8k]`.
- `i_wb_data`  in  32  write data, lane-aligned.
- `o_wb_data`  out  32  read data; valid in the ack cycle of a read.
- `o_wb_ack`  out  1  one-cycle completion pulse.
- `o_wb_stall`  out  1  high while a request is in flight; strobes are ignored while it is high.

## Operation
- States:
  - S_IDLE: stall is 0, ack is 0.
  - S_WAIT: counts down the remaining latency.
  - S_ACK: ack is 1 for exactly one cycle.
- Acceptance: in S_IDLE with `i_wb_stb=1`, capture addr, we, sel and data.
  - If `LATENCY==1`, go to S_ACK.
  - Otherwise go to S_WAIT with the counter loaded with `LATENCY-2`.
- S_WAIT: when the counter reaches 0, go to S_ACK; otherwise decrement.
- S_ACK: unconditionally return to S_IDLE.
- Memory access commits on the edge that enters S_ACK. That edge is the acceptance edge when `LATENCY==1`, using the live inputs.
- Write:
  - Each lane k with `sel[k]=1` gets byte k of the data; unselected lanes keep their contents.
  - `sel=4'b0000` is a legal no-op write and still acks.
  - `o_wb_data` keeps its previous value.
- Read: `o_wb_data` = the full stored word. `sel` is ignored for reads; the initiator picks the lanes.
- Addresses at or above the depth alias modulo 2^ADDR_WIDTH; there is no error response.
- `i_wb_stb` in S_WAIT or S_ACK (stall high) has no effect and is not queued.
- Memory contents are not initialised; the bench must write before reading.

## Timing
- Reset (`i_reset_n` low, asynchronous):
  - `o_wb_ack=0`, `o_wb_stall=0`, `o_wb_data=32'h0`.
  - State returns to S_IDLE and the counter to 0.
- Reset mid-operation: the in-flight request is dropped with no ack.
  - A write not yet committed is lost; memory contents are otherwise preserved.
- Request sampled in cycle N:
  - `o_wb_stall` is high in cycles N+1..N+LATENCY.
  - `o_wb_ack` is high in cycle N+LATENCY only.
  - Stall is low again at N+LATENCY+1.
- Back-to-back: the next request can be accepted at the earliest in cycle N+LATENCY+1. Throughput is one request per LATENCY+1 cycles.
- Stall is combinationally a function of state only: `state != S_IDLE`. There is no input-to-output combinational path.
- A read issued directly after a write to the same address returns the new data, because the write has committed before the read is accepted.

## Structure
- Shared include `wb_defs.vh`:
  - lane-select constants 4'b0001, 4'b0011, 4'b1100, 4'b1111;
  - sel/width encodings used with `cpu_mem_controller`.
- The state localparams are local to this block.
- One sub-module, `byte_lane_ram`:
  - four 8-bit × 2^ADDR_WIDTH arrays;
  - per-lane write enable and a synchronous registered read;
  - inferable as block RAM.
- The top level contains the FSM, the latency counter of width `$clog2(LATENCY)+1`, and the request capture registers.

## Test plan
- Reset then idle: hold `i_reset_n=0` for 3 cycles, then release.
  - Expect `o_wb_stall=0`, `o_wb_ack=0`, `o_wb_data=0`, with no ack in the next 10 cycles.
- Full-word write then read, `LATENCY=1`:
  - Write `addr=5`, `sel=4'b1111`, `data=32'hDEADBEEF` → ack 1 cycle later.
  - Read `addr=5` → ack with `o_wb_data=32'hDEADBEEF`.
- Byte-lane merge:
  - Write `addr=7` with `32'h11223344` and `sel=4'b1111`.
  - Write `addr=7` with `32'hAABBCCDD` and `sel=4'b0110`.
  - Read `addr=7` → `32'h11BBCC44`.
- Latency and stall, `LATENCY=4`:
  - Strobe a read in cycle 10 → stall is high in cycles 11–14 and ack is high only in cycle 14.
  - A second strobe in cycle 12 is ignored, giving exactly one ack.
- Aliasing, `ADDR_WIDTH=4`:
  - Write `addr=3` with `32'h0000CAFE`.
  - Read `addr=19` → `32'h0000CAFE`.
- Reset mid-operation, `LATENCY=3`:
  - Strobe a write of `32'h12345678` to `addr=2` (prior value `32'h0`) and pull reset in cycle N+1.
  - Expect no ack, and a subsequent read of `addr=2` returns `32'h0`.

Source files
------------

// File: rtl/wb_ram_responder_pkg.sv
// wb_ram_responder_pkg: lane-select constants and access-size encodings shared with cpu_mem_controller.
package wb_ram_responder_pkg;
  localparam logic [3:0] SEL_BYTE0 = 4'b0001;
  localparam logic [3:0] SEL_HALF0 = 4'b0011;
  localparam logic [3:0] SEL_HALF1 = 4'b1100;
  localparam logic [3:0] SEL_WORD  = 4'b1111;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  function automatic logic [3:0] lane_sel(size_e sz, logic [1:0] off);
    return sz == SZ_WORD ? SEL_WORD : sz == SZ_HALF ? (off[1] ? SEL_HALF1 : SEL_HALF0) : SEL_BYTE0 << off;
  endfunction
endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: four byte-wide arrays with per-lane write enable and a registered read port.
module byte_lane_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [2**ADDR_WIDTH];
    logic [7:0] q;
    always_ff @(posedge clk)
      if (en && we && sel[k]) mem[addr] <= wdata[8*k +: 8];
    // Read register is kept out of the array process so the array still maps to block RAM.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (en && !we) q <= mem[addr];
    assign rdata[8*k +: 8] = q;
  end
endmodule

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: single-outstanding Wishbone responder with fixed ack latency over a byte-lane RAM.
module wb_ram_responder
  import wb_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall
);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LOAD = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
  localparam bit LIVE = LATENCY == 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;
  state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, ram_addr;
  logic we_q, ram_we, accept, commit;
  logic [3:0] sel_q, ram_sel;
  logic [31:0] data_q, ram_wdata;
  logic unused_addr;
  assign unused_addr = ^i_wb_addr[31:ADDR_WIDTH];
  assign accept = state == S_IDLE && i_wb_stb;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    commit = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        state_d = LIVE ? S_ACK : S_WAIT;
        cnt_d = LOAD;
        commit = LIVE;
      end
      S_WAIT: if (cnt == '0) begin
        state_d = S_ACK;
        commit = 1'b1;
      end else cnt_d = cnt - 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      addr_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      addr_q <= i_wb_addr[ADDR_WIDTH-1:0];
      we_q <= i_wb_we;
      sel_q <= i_wb_sel;
      data_q <= i_wb_data;
    end
  // With single-cycle latency the access happens on the acceptance edge, so it uses the live bus.
  assign ram_addr  = LIVE ? i_wb_addr[ADDR_WIDTH-1:0] : addr_q;
  assign ram_we    = LIVE ? i_wb_we : we_q;
  assign ram_sel   = LIVE ? i_wb_sel : sel_q;
  assign ram_wdata = LIVE ? i_wb_data : data_q;
  byte_lane_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (commit),
    .we    (ram_we),
    .sel   (ram_sel),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (o_wb_data)
  );
  assign o_wb_ack = state == S_ACK;
  assign o_wb_stall = state != S_IDLE;
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed checks on three responder configurations (latency 1, 4 and 3).
module tb_wb_ram_responder;
  import wb_ram_responder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] stb = '0;
  logic we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0] sel = '0;
  logic [31:0] wdata = '0;
  logic ack [3];
  logic stall [3];
  logic [31:0] rd [3];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  wb_ram_responder #(.ADDR_WIDTH(4), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_stb(stb[0]), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_sel(sel), .i_wb_data(wdata), .o_wb_data(rd[0]), .o_wb_ack(ack[0]), .o_wb_stall(stall[0]));
  wb_ram_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_stb(stb[1]), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_sel(sel), .i_wb_data(wdata), .o_wb_data(rd[1]), .o_wb_ack(ack[1]), .o_wb_stall(stall[1]));
  wb_ram_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_l3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_stb(stb[2]), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_sel(sel), .i_wb_data(wdata), .o_wb_data(rd[2]), .o_wb_ack(ack[2]), .o_wb_stall(stall[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One request on DUT d; returns read data at the ack and the cycles from request to ack.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] data, output int lat);
    @(negedge clk);
    we = w; addr = a; sel = s; wdata = wd; stb[d] = 1'b1;
    @(negedge clk);
    stb[d] = 1'b0;
    lat = 1;
    while (!ack[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = rd[d];
    @(negedge clk);
    check($sformatf("stall_after_ack_d%0d", d), 32'(stall[d]), 0);
  endtask
  initial begin
    logic [31:0] data;
    int lat, acks;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_stall_d%0d", d), 32'(stall[d]), 0);
      check($sformatf("rst_ack_d%0d", d), 32'(ack[d]), 0);
      check($sformatf("rst_data_d%0d", d), rd[d], 0);
    end
    rst_n = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[0] || ack[1] || ack[2]) acks++;
    end
    check("idle_acks", acks, 0);
    xfer(0, 1'b1, 5, SEL_WORD, 32'hDEADBEEF, data, lat);
    check("l1_wr_lat", lat, 1);
    xfer(0, 1'b0, 5, SEL_WORD, 0, data, lat);
    check("l1_rd_lat", lat, 1);
    check("l1_rd_data", data, 32'hDEADBEEF);
    xfer(0, 1'b1, 7, SEL_WORD, 32'h11223344, data, lat);
    xfer(0, 1'b1, 7, 4'b0110, 32'hAABBCCDD, data, lat);
    xfer(0, 1'b0, 7, 4'b0001, 0, data, lat);
    check("merge_data", data, 32'h11BBCC44);
    xfer(0, 1'b1, 7, 4'b0000, 32'hFFFFFFFF, data, lat);
    check("nop_wr_lat", lat, 1);
    check("wr_keeps_rdata", rd[0], 32'h11BBCC44);
    xfer(0, 1'b0, 7, SEL_WORD, 0, data, lat);
    check("nop_wr_data", data, 32'h11BBCC44);
    xfer(0, 1'b1, 3, SEL_WORD, 32'h0000CAFE, data, lat);
    xfer(0, 1'b0, 19, SEL_WORD, 0, data, lat);
    check("alias_19", data, 32'h0000CAFE);
    xfer(0, 1'b0, 32'hFFFFFFF3, SEL_WORD, 0, data, lat);
    check("alias_high", data, 32'h0000CAFE);
    xfer(1, 1'b1, 1, SEL_WORD, 32'hA5A5A5A5, data, lat);
    check("l4_wr_lat", lat, 4);
    @(negedge clk);
    we = 1'b0; addr = 1; sel = SEL_WORD; stb[1] = 1'b1;
    acks = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1 || i == 3) stb[1] = 1'b0;
      check($sformatf("l4_stall_c%0d", i), 32'(stall[1]), 32'(i <= 4));
      check($sformatf("l4_ack_c%0d", i), 32'(ack[1]), 32'(i == 4));
      if (i == 4) check("l4_rd_data", rd[1], 32'hA5A5A5A5);
      if (ack[1]) acks++;
      if (i == 2) stb[1] = 1'b1;
    end
    check("l4_ack_count", acks, 1);
    xfer(1, 1'b1, 6, SEL_WORD, 32'h0F0F0F0F, data, lat);
    xfer(1, 1'b0, 6, SEL_WORD, 0, data, lat);
    check("l4_raw_data", data, 32'h0F0F0F0F);
    check("l4_rd_lat", lat, 4);
    xfer(2, 1'b1, 2, SEL_WORD, 32'h0, data, lat);
    check("l3_wr_lat", lat, 3);
    @(negedge clk);
    we = 1'b1; addr = 2; sel = SEL_WORD; wdata = 32'h12345678; stb[2] = 1'b1;
    @(negedge clk);
    stb[2] = 1'b0;
    rst_n = 1'b0;
    #1 check("midrst_stall", 32'(stall[2]), 0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[2]) acks++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack[2]) acks++;
    end
    check("midrst_acks", acks, 0);
    xfer(2, 1'b0, 2, SEL_WORD, 0, data, lat);
    check("midrst_rd_data", data, 32'h0);
    check("midrst_rd_lat", lat, 3);
    xfer(0, 1'b0, 5, SEL_WORD, 0, data, lat);
    check("mem_kept_after_rst", data, 32'hDEADBEEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
